// File: rtl/wb_stage_if.sv
// rtl/wb_stage_if.sv - writeback stage bus: memory-stage result, multiply stream, register-file write port
interface wb_stage_if;
  logic        stall;
  logic        flush;
  logic        memValid;
  logic        memWe;
  logic [0:4]  memRd;
  logic [0:31] memAluRes;
  logic        memLoad;
  logic [0:2]  memLdType;
  logic [0:31] memLdData;
  logic        mulValid;
  logic        mulReady;
  logic [0:4]  mulRd;
  logic [0:31] mulRes;
  logic        we;
  logic [0:4]  wrAddr;
  logic [0:31] wrData;
  logic [0:31] mulPend;

  modport master (
    output stall, flush, memValid, memWe, memRd, memAluRes, memLoad, memLdType, memLdData,
    output mulValid, mulRd, mulRes,
    input  mulReady, we, wrAddr, wrData, mulPend
  );

  modport slave (
    input  stall, flush, memValid, memWe, memRd, memAluRes, memLoad, memLdType, memLdData,
    input  mulValid, mulRd, mulRes,
    output mulReady, we, wrAddr, wrData, mulPend
  );
endinterface

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - writeback latch with load alignment, multiply-result FIFO and write-port arbitration
module wb_stage #(
  parameter int QDEPTH = 2
) (
  input logic       clk,
  input logic       rst_n,
  wb_stage_if.slave bus
);
  localparam logic [2:0] DEPTH = 3'(QDEPTH);
  localparam logic [1:0] LAST  = 2'(QDEPTH - 1);

  logic        v, wr, used;
  logic [0:4]  rd;
  logic [0:31] data;

  logic [0:4]  qRd   [4];
  logic [0:31] qData [4];
  logic [1:0]  head, tail, nextHead;
  logic [2:0]  count, tailSum;

  logic        pipeWr, popEn, pushEn, mulReadyC;
  logic        weC;
  logic [0:4]  wrAddrC;
  logic [0:31] wrDataC, loadVal, mulPendC;
  logic [0:7]  byteV;
  logic [0:15] halfV;

  // Big-endian lanes: offset 0 is the most significant byte.
  always_comb begin
    byteV = '0;
    case (bus.memAluRes[30:31])
      2'd0:    byteV = bus.memLdData[0:7];
      2'd1:    byteV = bus.memLdData[8:15];
      2'd2:    byteV = bus.memLdData[16:23];
      default: byteV = bus.memLdData[24:31];
    endcase
    halfV = bus.memAluRes[30] ? bus.memLdData[16:31] : bus.memLdData[0:15];
    case (bus.memLdType)
      3'b001:  loadVal = {{16{halfV[0]}}, halfV};
      3'b010:  loadVal = {16'b0, halfV};
      3'b011:  loadVal = {{24{byteV[0]}}, byteV};
      3'b100:  loadVal = {24'b0, byteV};
      default: loadVal = bus.memLdData;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v    <= 1'b0;
      wr   <= 1'b0;
      rd   <= '0;
      data <= '0;
      used <= 1'b0;
    end else if (!bus.stall) begin
      v    <= bus.memValid & ~bus.flush;
      wr   <= bus.memWe;
      rd   <= bus.memRd;
      data <= bus.memLoad ? loadVal : bus.memAluRes;
      used <= 1'b0;
    end else if (pipeWr) begin
      used <= 1'b1;
    end
  end

  assign pipeWr    = v & wr & ~used & (rd != 5'd0);
  assign mulReadyC = count < DEPTH;
  // Zero-destination results are acknowledged but never occupy a slot.
  assign pushEn    = bus.mulValid & mulReadyC & (bus.mulRd != 5'd0);
  assign tailSum   = {1'b0, head} + count;
  assign tail      = (tailSum >= DEPTH) ? 2'(tailSum - DEPTH) : tailSum[1:0];
  assign nextHead  = (head == LAST) ? 2'd0 : head + 2'd1;

  always_comb begin
    weC     = 1'b0;
    wrAddrC = '0;
    wrDataC = '0;
    popEn   = 1'b0;
    if (pipeWr) begin
      weC     = 1'b1;
      wrAddrC = rd;
      wrDataC = data;
    end else if (count != 3'd0) begin
      weC     = 1'b1;
      wrAddrC = qRd[head];
      wrDataC = qData[head];
      popEn   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      count <= '0;
    end else begin
      if (popEn) head <= nextHead;
      count <= count + {2'b0, pushEn} - {2'b0, popEn};
    end
  end

  always_ff @(posedge clk) begin
    if (pushEn) begin
      qRd[tail]   <= bus.mulRd;
      qData[tail] <= bus.mulRes;
    end
  end

  always_comb begin
    logic [2:0] slot;
    mulPendC = '0;
    slot     = '0;
    for (int i = 0; i < 4; i++) begin
      slot = {1'b0, head} + 3'(i);
      if (slot >= DEPTH) slot = slot - DEPTH;
      if (3'(i) < count) mulPendC[qRd[slot[1:0]]] = 1'b1;
    end
  end

  assign bus.we       = weC;
  assign bus.wrAddr   = wrAddrC;
  assign bus.wrData   = wrDataC;
  assign bus.mulReady = mulReadyC;
  assign bus.mulPend  = mulPendC;
endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - directed and randomized checks of wb_stage against a queue-based reference model
module tb_wb_stage;
  localparam int QD = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_stage_if mif ();
  wb_stage #(.QDEPTH(QD)) dut (.clk(clk), .rst_n(rst_n), .bus(mif));

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] d;
  } ent_t;

  ent_t        q[$];
  logic        mV, mWr, mUsed;
  logic [4:0]  mRd;
  logic [31:0] mData;
  int total = 0;
  int bad = 0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] alignLoad(input logic [2:0] t, input logic [31:0] a, input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    int off;
    off = int'(a & 32'd3);
    b = 8'((d >> (8 * (3 - off))) & 32'hFF);
    h = a[1] ? d[15:0] : d[31:16];
    case (t)
      3'd1:    return {{16{h[15]}}, h};
      3'd2:    return {16'h0, h};
      3'd3:    return {{24{b[7]}}, b};
      3'd4:    return {24'h0, b};
      default: return d;
    endcase
  endfunction

  task automatic modelReset();
    q.delete();
    mV = 0; mWr = 0; mUsed = 0; mRd = 0; mData = 0;
  endtask

  task automatic compareAll();
    logic        pw, eWe;
    logic [4:0]  eA;
    logic [31:0] eD;
    logic [0:31] eP;
    pw = mV && mWr && !mUsed && (mRd != 0);
    eWe = 0; eA = 0; eD = 0;
    if (pw) begin
      eWe = 1; eA = mRd; eD = mData;
    end else if (q.size() > 0) begin
      eWe = 1; eA = q[0].rd; eD = q[0].d;
    end
    eP = '0;
    foreach (q[i]) eP[q[i].rd] = 1'b1;
    checkVal("we", 32'(mif.we), 32'(eWe));
    checkVal("wrAddr", 32'(mif.wrAddr), 32'(eA));
    checkVal("wrData", mif.wrData, eD);
    checkVal("mulPend", mif.mulPend, eP);
    checkVal("mulReady", 32'(mif.mulReady), 32'(q.size() < QD));
  endtask

  // Apply the current inputs across one rising edge, then compare at the falling edge.
  task automatic step();
    logic pw, acc;
    logic [31:0] la;
    pw  = mV && mWr && !mUsed && (mRd != 0);
    acc = mif.mulValid && (q.size() < QD);
    la  = mif.memLoad ? alignLoad(mif.memLdType, mif.memAluRes, mif.memLdData) : mif.memAluRes;
    if (!mif.stall) begin
      mV = mif.memValid && !mif.flush; mWr = mif.memWe; mRd = mif.memRd; mData = la; mUsed = 0;
    end else if (pw) begin
      mUsed = 1;
    end
    if (!pw && q.size() > 0) void'(q.pop_front());
    if (acc && mif.mulRd != 0) q.push_back('{rd: mif.mulRd, d: mif.mulRes});
    @(posedge clk);
    @(negedge clk);
    compareAll();
  endtask

  task automatic idle();
    mif.stall = 0; mif.flush = 0; mif.memValid = 0; mif.memWe = 0; mif.memRd = 0;
    mif.memAluRes = 0; mif.memLoad = 0; mif.memLdType = 0; mif.memLdData = 0;
    mif.mulValid = 0; mif.mulRd = 0; mif.mulRes = 0;
  endtask

  task automatic pipe(input int rd, input logic [31:0] val);
    mif.memValid = 1; mif.memWe = 1; mif.memLoad = 0; mif.memRd = 5'(rd); mif.memAluRes = val;
  endtask

  task automatic mul(input int rd, input logic [31:0] val);
    mif.mulValid = 1; mif.mulRd = 5'(rd); mif.mulRes = val;
  endtask

  initial begin
    int n7, n9;
    idle();
    modelReset();
    #1;
    checkVal("rst_we", 32'(mif.we), 0);
    checkVal("rst_wrAddr", 32'(mif.wrAddr), 0);
    checkVal("rst_wrData", mif.wrData, 0);
    checkVal("rst_mulPend", mif.mulPend, 0);
    checkVal("rst_mulReady", 32'(mif.mulReady), 1);
    @(negedge clk);
    rst_n = 1;
    step();

    pipe(5, 32'h0000_0002); mif.memLoad = 1; mif.memLdType = 3'b011; mif.memLdData = 32'h1122_F344;
    step();
    checkVal("lb_we", 32'(mif.we), 1);
    checkVal("lb_addr", 32'(mif.wrAddr), 5);
    checkVal("lb_data", mif.wrData, 32'hFFFF_FFF3);
    mif.memLdType = 3'b010;
    step();
    checkVal("lhu_data", mif.wrData, 32'h0000_F344);

    idle(); n7 = 0; n9 = 0;
    pipe(7, 32'hDEAD_BEEF);
    step(); if (mif.we && mif.wrAddr == 7) n7++;
    pipe(8, 32'h1234_5678); mif.stall = 1;
    step(); if (mif.we && mif.wrAddr == 7) n7++;
    mul(9, 32'h0000_0099);
    step(); if (mif.we && mif.wrAddr == 7) n7++;
    if (mif.we && mif.wrAddr == 9) n9++;
    checkVal("stall_mul_addr", 32'(mif.wrAddr), 9);
    mif.mulValid = 0;
    step(); if (mif.we && mif.wrAddr == 7) n7++;
    if (mif.we && mif.wrAddr == 9) n9++;
    checkVal("stall_once", 32'(n7), 1);
    checkVal("stall_mul_once", 32'(n9), 1);
    idle(); step(); step();

    pipe(10, 32'hA); mul(1, 32'h11); step();
    pipe(11, 32'hB); mul(2, 32'h22); step();
    checkVal("fill_ready", 32'(mif.mulReady), 0);
    checkVal("fill_pend", mif.mulPend, 32'h6000_0000);
    pipe(12, 32'hC); mul(3, 32'h33); step();
    checkVal("fill_hold_addr", 32'(mif.wrAddr), 12);
    mif.memValid = 0; step();
    checkVal("drain_first", 32'(mif.wrAddr), 1);
    step();
    checkVal("drain_second", 32'(mif.wrAddr), 2);
    checkVal("drain_ready", 32'(mif.mulReady), 1);
    step();
    checkVal("late_accept", 32'(mif.wrAddr), 3);
    idle(); step();

    mul(0, 32'h55); step();
    checkVal("zero_mul_we", 32'(mif.we), 0);
    checkVal("zero_mul_pend", mif.mulPend, 0);
    idle(); pipe(12, 32'hE); mul(4, 32'h44); step();
    idle(); pipe(0, 32'hF); step();
    checkVal("zero_rd_drain", 32'(mif.wrAddr), 4);
    idle(); pipe(6, 32'h66); mif.flush = 1; step();
    checkVal("flush_we", 32'(mif.we), 0);

    idle(); pipe(13, 32'h1); mul(5, 32'h5); step();
    pipe(14, 32'h2); mul(6, 32'h6); step();
    idle();
    #2 rst_n = 0;
    #1;
    modelReset();
    checkVal("mid_rst_we", 32'(mif.we), 0);
    checkVal("mid_rst_pend", mif.mulPend, 0);
    checkVal("mid_rst_ready", 32'(mif.mulReady), 1);
    @(negedge clk);
    rst_n = 1;
    n7 = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (mif.we) n7++;
    end
    checkVal("post_rst_writes", 32'(n7), 0);

    for (int i = 0; i < 1500; i++) begin
      mif.stall     = ($urandom_range(0, 3) == 0);
      mif.flush     = ($urandom_range(0, 9) == 0);
      mif.memValid  = ($urandom_range(0, 9) < 7);
      mif.memWe     = ($urandom_range(0, 9) < 7);
      mif.memRd     = ($urandom_range(0, 6) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      mif.memAluRes = $urandom;
      mif.memLoad   = $urandom_range(0, 1) == 1;
      mif.memLdType = 3'($urandom_range(0, 7));
      mif.memLdData = $urandom;
      mif.mulValid  = ($urandom_range(0, 9) < 4);
      mif.mulRd     = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      mif.mulRes    = $urandom;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
